// File: rtl/audio_level_meter.sv
// audio_level_meter: per-frame audio peak envelope for the overlay bar graph.
// Optional peak hold is enabled by defining PEAK_HOLD_EN.
module audio_level_meter #(
  parameter int unsigned DECAY       = 4,
  parameter int unsigned SHIFT       = 7,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic [15:0] audio_in,
  input  logic        audio_stb,
  input  logic        vsync,
  input  logic        en,
  output logic [7:0]  level,
  output logic        level_stb
);

  if (SHIFT > 7) begin : g_bad_shift
    $error("audio_level_meter: SHIFT must be 0..7");
  end

  if (HOLD_FRAMES > 255) begin : g_bad_hold
    $error("audio_level_meter: HOLD_FRAMES must be 0..255");
  end

  localparam logic [7:0] DEC8 = DECAY[7:0];

  logic        vsync_d;
  logic        vs_rise;
  logic [14:0] peak;
  logic [14:0] peak_nxt;
  logic [15:0] neg;
  logic [14:0] mag;
  logic [14:0] shifted;
  logic [7:0]  fp;
  logic [7:0]  decayed;
  logic [7:0]  level_nxt;

  assign vs_rise = vsync & ~vsync_d;
  assign neg     = ~audio_in + 16'd1;

  // Absolute value; the most negative code saturates instead of wrapping.
  always_comb begin
    mag = audio_in[14:0];
    if (audio_in[15]) begin
      if (audio_in == 16'h8000)
        mag = 15'h7fff;
      else
        mag = neg[14:0];
    end
  end

  // Scale the frame peak down to 8 bits, clamping at full scale.
  always_comb begin
    shifted = peak >> SHIFT;
    fp      = shifted[7:0];
    if (|shifted[14:8])
      fp = 8'hff;
  end

  // Level after one decay step, floored at zero.
  always_comb begin
    decayed = 8'd0;
    if (level > DEC8)
      decayed = level - DEC8;
  end

  // Peak accumulator; a sample in the edge cycle opens the new frame.
  always_comb begin
    peak_nxt = peak;
    if (!en)
      peak_nxt = 15'd0;
    else if (vs_rise)
      peak_nxt = audio_stb ? mag : 15'd0;
    else if (audio_stb && (mag > peak))
      peak_nxt = mag;
  end

`ifdef PEAK_HOLD_EN

  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_FRAMES);

  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nxt;

  // Level update with hold: new max reloads the counter, decay waits.
  always_comb begin
    level_nxt = level;
    hold_nxt  = hold;
    if (!en) begin
      level_nxt = 8'd0;
      hold_nxt  = '0;
    end else if (vs_rise) begin
      if (fp >= level) begin
        level_nxt = fp;
        hold_nxt  = HOLD_LD;
      end else if (hold != '0) begin
        hold_nxt  = hold - 1'b1;
      end else begin
        level_nxt = decayed;
      end
    end
  end

  // Hold counter register.
  always_ff @(posedge clk_vid) begin
    if (reset)
      hold <= '0;
    else
      hold <= hold_nxt;
  end

`else

  // Level update: rise to a new max at once, otherwise fall by DECAY.
  always_comb begin
    level_nxt = level;
    if (!en)
      level_nxt = 8'd0;
    else if (vs_rise)
      level_nxt = (fp >= level) ? fp : decayed;
  end

`endif

  // State registers: edge detector, peak, level and its strobe.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      vsync_d   <= 1'b0;
      peak      <= 15'd0;
      level     <= 8'd0;
      level_stb <= 1'b0;
    end else begin
      vsync_d   <= vsync;
      peak      <= peak_nxt;
      level     <= level_nxt;
      level_stb <= vs_rise;
    end
  end

endmodule
